// File: rtl/hour0_digit_if.sv
// rtl/hour0_digit_if.sv - event/level/value bundle between the hours units digit and its neighbours
interface hour0_digit_if;
  logic       decrease;
  logic       set_btn;
  logic       tens_zero;
  logic       tens_two;
  logic [3:0] value;
  logic       borrow;
  logic       over_set;
  logic       zero;

  modport master (
    output decrease, set_btn, tens_zero, tens_two,
    input  value, borrow, over_set, zero
  );

  modport slave (
    input  decrease, set_btn, tens_zero, tens_two,
    output value, borrow, over_set, zero
  );
endinterface

// File: rtl/hour0_digit.sv
// rtl/hour0_digit.sv - units-of-hours digit of the count-down clock with set-button stepping
// HOUR0_AUTOREPEAT_EN: when defined, a held set button auto-repeats; otherwise one step per press.
module hour0_digit #(
  parameter int HOLD_CYCLES   = 16,
  parameter int REPEAT_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input logic          clk_out,
  input logic          rst_n,
  hour0_digit_if.slave bus
);

  logic [3:0] value_q, value_d;
  logic       zero_q;
  logic       borrow_c, over_set_c;
  logic       step;

`ifdef HOUR0_AUTOREPEAT_EN
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HOLD   = 2'd1,
    S_REPEAT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;

  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    step    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.set_btn) begin
          step    = 1'b1;
          timer_d = CNT_W'(HOLD_CYCLES - 1);
          state_d = S_HOLD;
        end
      end
      S_HOLD, S_REPEAT: begin
        if (!bus.set_btn) begin
          state_d = S_IDLE;
        end else if (timer_q == '0) begin
          step    = 1'b1;
          timer_d = CNT_W'(REPEAT_CYCLES - 1);
          state_d = S_REPEAT;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
`else
  logic        set_btn_q;
  logic [31:0] unused_cfg;

  // Timing parameters have no meaning without auto-repeat.
  assign unused_cfg = 32'(HOLD_CYCLES ^ REPEAT_CYCLES ^ CNT_W);

  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      set_btn_q <= 1'b0;
    end else begin
      set_btn_q <= bus.set_btn;
    end
  end

  assign step = bus.set_btn & ~set_btn_q;
`endif

  // A borrow always wins; a step in the same cycle is dropped.
  always_comb begin
    value_d    = value_q;
    borrow_c   = 1'b0;
    over_set_c = 1'b0;
    if (bus.decrease) begin
      if (value_q == 4'd0) begin
        borrow_c = 1'b1;
        value_d  = bus.tens_zero ? 4'd3 : 4'd9;
      end else begin
        value_d = value_q - 4'd1;
      end
    end else if (step) begin
      if ((value_q == 4'd9) || (bus.tens_two && (value_q >= 4'd3))) begin
        over_set_c = 1'b1;
        value_d    = 4'd0;
      end else begin
        value_d = value_q + 4'd1;
      end
    end else if (bus.tens_two && (value_q > 4'd3)) begin
      value_d = 4'd3;
    end
  end

  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= 4'd0;
      zero_q  <= 1'b0;
    end else begin
      value_q <= value_d;
      zero_q  <= (value_q == 4'd0);
    end
  end

  assign bus.value    = value_q;
  assign bus.zero     = zero_q;
  assign bus.borrow   = borrow_c;
  assign bus.over_set = over_set_c;

endmodule

// File: tb/tb_hour0_digit.sv
// tb/tb_hour0_digit.sv - directed self-checking bench for hour0_digit
module tb_hour0_digit;

  logic clk_out = 1'b0;
  logic rst_n   = 1'b0;
  int   n_cmp   = 0;
  int   n_err   = 0;

  hour0_digit_if bus ();

  hour0_digit dut (
    .clk_out (clk_out),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #5 clk_out = ~clk_out;

`ifdef HOUR0_AUTOREPEAT_EN
  localparam logic [3:0] HOLD30_VALUE = 4'd5;
  localparam int         PRESS_TO_5   = 0;
`else
  localparam logic [3:0] HOLD30_VALUE = 4'd1;
  localparam int         PRESS_TO_5   = 4;
`endif

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_out);
    #1;
  endtask

  task automatic press_once();
    bus.set_btn = 1'b1;
    tick();
    bus.set_btn = 1'b0;
    tick();
  endtask

  initial begin
    bus.decrease  = 1'b0;
    bus.set_btn   = 1'b1;
    bus.tens_zero = 1'b0;
    bus.tens_two  = 1'b0;
    repeat (3) tick();
    #1;
    chk("rst_value", bus.value, 4'd0);
    chk("rst_zero", {3'b0, bus.zero}, 4'd0);
    chk("rst_borrow", {3'b0, bus.borrow}, 4'd0);
    chk("rst_over_set", {3'b0, bus.over_set}, 4'd0);

    // Button held through reset release counts as a fresh press.
    rst_n = 1'b1;
    tick();
    chk("release_step", bus.value, 4'd1);
    bus.set_btn = 1'b0;
    tick();
    chk("release_hold", bus.value, 4'd1);

    bus.tens_zero = 1'b1;
    bus.decrease  = 1'b1;
    #1;
    chk("dec_nz_borrow", {3'b0, bus.borrow}, 4'd0);
    tick();
    bus.decrease = 1'b0;
    chk("dec_to_0", bus.value, 4'd0);
    chk("zero_lag", {3'b0, bus.zero}, 4'd0);

    bus.decrease = 1'b1;
    #1;
    chk("wrap23_borrow", {3'b0, bus.borrow}, 4'd1);
    chk("wrap23_over_set", {3'b0, bus.over_set}, 4'd0);
    tick();
    bus.decrease = 1'b0;
    chk("wrap23_value", bus.value, 4'd3);
    chk("zero_set", {3'b0, bus.zero}, 4'd1);
    tick();
    chk("zero_clear", {3'b0, bus.zero}, 4'd0);

    for (int i = 0; i < 3; i++) begin
      bus.decrease = 1'b1;
      tick();
      bus.decrease = 1'b0;
    end
    chk("count_down", bus.value, 4'd0);

    bus.tens_zero = 1'b0;
    bus.decrease  = 1'b1;
    #1;
    chk("wrap9_borrow", {3'b0, bus.borrow}, 4'd1);
    tick();
    bus.decrease = 1'b0;
    chk("wrap9_value", bus.value, 4'd9);

    bus.set_btn = 1'b1;
    #1;
    chk("set9_over_set", {3'b0, bus.over_set}, 4'd1);
    chk("set9_borrow", {3'b0, bus.borrow}, 4'd0);
    tick();
    chk("set9_value", bus.value, 4'd0);
    bus.set_btn = 1'b0;
    #1;
    chk("set9_pulse_end", {3'b0, bus.over_set}, 4'd0);
    tick();

    bus.tens_two = 1'b1;
    for (int i = 0; i < 3; i++) press_once();
    chk("set_to_3", bus.value, 4'd3);
    bus.set_btn = 1'b1;
    #1;
    chk("set23_over_set", {3'b0, bus.over_set}, 4'd1);
    tick();
    chk("set23_value", bus.value, 4'd0);
    bus.set_btn = 1'b0;
    tick();

    bus.tens_two = 1'b0;
    bus.set_btn  = 1'b1;
    repeat (30) tick();
    chk("hold30_value", bus.value, HOLD30_VALUE);
    bus.set_btn = 1'b0;
    tick();

    for (int i = 0; i < PRESS_TO_5; i++) press_once();
    chk("reach_5", bus.value, 4'd5);
    bus.decrease = 1'b1;
    bus.set_btn  = 1'b1;
    #1;
    chk("collide_over_set", {3'b0, bus.over_set}, 4'd0);
    chk("collide_borrow", {3'b0, bus.borrow}, 4'd0);
    tick();
    bus.decrease = 1'b0;
    bus.set_btn  = 1'b0;
    chk("collide_value", bus.value, 4'd4);
    repeat (2) tick();
    chk("collide_no_defer", bus.value, 4'd4);

    for (int i = 0; i < 3; i++) press_once();
    chk("reach_7", bus.value, 4'd7);
    bus.tens_two = 1'b1;
    #1;
    chk("guard_borrow", {3'b0, bus.borrow}, 4'd0);
    chk("guard_over_set", {3'b0, bus.over_set}, 4'd0);
    tick();
    chk("guard_value", bus.value, 4'd3);

    bus.tens_two = 1'b0;
    bus.set_btn  = 1'b1;
    tick();
    chk("hold_first_step", bus.value, 4'd4);
    repeat (3) tick();
    chk("hold_waiting", bus.value, 4'd4);
    rst_n = 1'b0;
    #1;
    chk("async_rst_value", bus.value, 4'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_step", bus.value, 4'd1);
    bus.set_btn = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
